mult32_tile_sequencer: RTL and testbench

//   Iterative 32x32 unsigned multiplier controller. It time-shares a single 8x8 wallace8

---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult32_tile_sequencer_wallace8.sv | 42 ++++
 rtl/mult32_tile_sequencer.sv | 142 ++++++++++++++
 tb/tb_mult32_tile_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the iterative 32x32 multiplier
//               sequencer built around a single 8x8 wallace8 tile.
// Revision    : 1.0  initial release
// ============================================================================
package mult_pkg;

    // Sequencer states; code 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Tile geometry: one 8x8 tile, four byte lanes per operand.
    localparam int TILE_W = 8;
    localparam int NTILE  = 4;

    // Count value of the final byte-pair cycle (NTILE*NTILE - 1).
    localparam logic [3:0] LAST_CNT = 4'd15;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult32_tile_sequencer_wallace8.sv
`default_nettype none
// ============================================================================
// Module      : wallace8
// Description : Combinational 8x8 unsigned multiplier. Partial products are
//               folded through a chain of 3:2 carry-save compressors and
//               resolved with one final carry-propagate add.
// Revision    : 1.0  initial release
// ============================================================================
module wallace8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [15:0] w_pp [8];

    // One shifted AND row per multiplier bit.
    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_pp
            assign w_pp[g] = {8'b0, a & {8{b[g]}}} << g;
        end
    endgenerate

    // Carry-save reduction of the rows, then a single final add. Carries
    // shifted out of bit 15 are always zero because 255*255 fits in 16 bits.
    always_comb begin
        logic [15:0] w_s;
        logic [15:0] w_c;
        logic [15:0] w_t;
        w_s = '0;
        w_c = '0;
        for (int k = 0; k < 8; k++) begin
            w_t = w_s;
            w_s = w_t ^ w_c ^ w_pp[k];
            w_c = ((w_t & w_c) | (w_t & w_pp[k]) | (w_c & w_pp[k])) << 1;
        end
        p = w_s + w_c;
    end

endmodule : wallace8
`default_nettype wire

// File: rtl/mult32_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult32_tile_sequencer
// Description : Iterative 32x32 -> 64 unsigned multiplier. A single 8x8 tile
//               is time-shared over all 16 byte pairs; each RUN cycle selects
//               one A-byte/B-byte pair, shifts the tile result into place and
//               adds it into a 64-bit accumulator. Valid/ready on both sides.
// Revision    : 1.0  initial release
// ============================================================================
module mult32_tile_sequencer #(
    parameter int WIDTH  = 32,
    parameter int TILE_W = 8,
    parameter int NTILE  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    import mult_pkg::*;

    // WIDTH must equal NTILE*TILE_W; LAST_CNT assumes NTILE == 4.
    localparam int IDX_W  = $clog2(NTILE);
    localparam int CNT_W  = 2 * IDX_W;
    localparam int PROD_W = 2 * WIDTH;
    localparam int SH_W   = $clog2(PROD_W);
    localparam int TSH    = $clog2(TILE_W);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_a_q;
    logic [WIDTH-1:0]    r_b_q;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   r_product;

    logic                w_accept;
    logic                w_last;
    logic [IDX_W-1:0]    w_i;
    logic [IDX_W-1:0]    w_j;
    logic [TILE_W-1:0]   w_tile_a;
    logic [TILE_W-1:0]   w_tile_b;
    logic [2*TILE_W-1:0] w_tile_p;
    logic [SH_W-1:0]     w_shamt;
    logic [PROD_W-1:0]   w_partial;
    logic [PROD_W-1:0]   w_acc_sum;

    // Counter low half walks the A bytes, high half walks the B bytes.
    assign w_i      = r_cnt[IDX_W-1:0];
    assign w_j      = r_cnt[CNT_W-1:IDX_W];
    assign w_last   = (r_cnt == CNT_W'(LAST_CNT));
    assign w_tile_a = r_a_q[TILE_W*int'(w_i) +: TILE_W];
    assign w_tile_b = r_b_q[TILE_W*int'(w_j) +: TILE_W];

    wallace8 u_tile (
        .a (w_tile_a),
        .b (w_tile_b),
        .p (w_tile_p)
    );

    // Byte-pair weight is TILE_W*(i+j) bits, 0..48 for the default geometry.
    assign w_shamt   = (SH_W'(w_i) + SH_W'(w_j)) << TSH;
    assign w_partial = PROD_W'(w_tile_p) << w_shamt;
    assign w_acc_sum = r_acc + w_partial;

    assign w_accept  = in_valid & in_ready;
    assign product   = r_product;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake/status outputs decoded from state.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Result slot frees up in the cycle the consumer takes it,
                // so a new operand pair can be accepted at the same edge.
                in_ready  = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, byte-pair accumulation and product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a_q <= a;
            r_b_q <= b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_product <= w_acc_sum;
            end
        end
    end

endmodule : mult32_tile_sequencer
`default_nettype wire

// File: tb/tb_mult32_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult32_tile_sequencer
// Description : Self-checking bench for mult32_tile_sequencer. A transaction
//               model predicts a*b, handshake readiness and result timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mult32_tile_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [63:0] product;

    mult32_tile_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          edge_cnt = 0;
    int          n_acc = 0;
    logic [63:0] exp_q[$];      // products of accepted, not yet consumed ops
    int          acc_edge_q[$]; // accept edge of ops whose result is not out yet
    bit          done_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle. Called at a falling edge after inputs are driven.
    // An op accepted at edge E spends 16 tile cycles, so its result is shown
    // after edge E+16 and a fully pipelined stream repeats every 17 edges.
    task automatic step();
        bit          acc_s;
        bit          oacc_s;
        bit          hold_s;
        bit          rdy_exp;
        logic [63:0] p_s;
        logic [31:0] a_s;
        logic [31:0] b_s;
        #1;
        rdy_exp = (acc_edge_q.size() == 0) && (!done_exp || out_ready);
        chk("busy", busy, acc_edge_q.size() != 0);
        chk("in_ready", in_ready, rdy_exp);
        chk("out_valid", out_valid, done_exp);
        if (done_exp) chk("product", product, exp_q[0]);
        acc_s  = in_valid && rdy_exp;
        oacc_s = done_exp && out_ready;
        hold_s = out_valid && !out_ready;
        p_s    = product;
        a_s    = a;
        b_s    = b;
        if (oacc_s) begin
            void'(exp_q.pop_front());
            done_exp = 1'b0;
        end
        @(posedge clk);
        edge_cnt++;
        if (acc_s) begin
            exp_q.push_back({32'b0, a_s} * {32'b0, b_s});
            acc_edge_q.push_back(edge_cnt);
            n_acc++;
        end
        @(negedge clk);
        if (acc_edge_q.size() != 0 && (edge_cnt - acc_edge_q[0]) == 16) begin
            void'(acc_edge_q.pop_front());
            done_exp = 1'b1;
        end
        if (hold_s) begin
            chk("hold_product", product, p_s);
            chk("hold_valid", out_valid, 1);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        exp_q.delete();
        acc_edge_q.delete();
        done_exp  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done_exp && n < limit) begin
            step();
            n++;
        end
        chk("wait_done_timeout", done_exp, 1);
    endtask

    // Single op; stray in_valid/out_ready and operand changes during RUN.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] expv, input string tag);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        step();
        while (!done_exp && acc_edge_q.size() != 0) begin
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            step();
        end
        chk(tag, product, expv);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [63:0] pe [3];

    initial begin
        int k;
        int outs;
        int prev_acc;
        int rise_edge[$];
        bit prev_ov;

        @(negedge clk);
        do_reset();

        // Corner operands.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max_x_max");
        run_op(32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF, "ffff_x_10001");
        run_op(32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, "msb_x_2");

        // Backpressure with a new op waiting, then accept on release.
        a = 32'd1000; b = 32'd1000; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_done(40);
        a = 32'hDEAD_BEEF; b = 32'h0000_0010; in_valid = 1'b1;
        repeat (5) begin
            step();
            chk("bp_product", product, 64'd1000000);
        end
        out_ready = 1'b1;
        step();
        chk("bp_accept", n_acc, 5);
        in_valid = 1'b0; out_ready = 1'b0;
        wait_done(40);
        chk("bp_next", product, 64'h0000_000D_EAD_BEEF0);
        out_ready = 1'b1;
        step();

        // Back-to-back stream with both handshakes held high.
        pa[0] = 32'd3; pb[0] = 32'd5;          pe[0] = 64'd15;
        pa[1] = 32'd7; pb[1] = 32'd9;          pe[1] = 64'd63;
        pa[2] = 32'd0; pb[2] = 32'hFFFF_FFFF;  pe[2] = 64'd0;
        k = 0; outs = 0; prev_ov = 1'b0; prev_acc = n_acc;
        a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 80 && outs < 3; n++) begin
            step();
            if (n_acc != prev_acc) begin
                prev_acc = n_acc;
                k++;
                if (k < 3) begin
                    a = pa[k]; b = pb[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                chk("b2b_pulse_width", prev_ov, 0);
                chk("b2b_product", product, pe[outs]);
                rise_edge.push_back(edge_cnt);
                outs++;
            end
            prev_ov = out_valid;
        end
        chk("b2b_outputs", outs, 3);
        if (rise_edge.size() == 3) begin
            chk("b2b_spacing0", rise_edge[1] - rise_edge[0], 17);
            chk("b2b_spacing1", rise_edge[2] - rise_edge[1], 17);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        step();

        // Reset part-way through RUN: that op never appears.
        a = 32'hCAFE_F00D; b = 32'h1234_5678; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        do_reset();
        out_ready = 1'b1;
        repeat (20) step();
        out_ready = 1'b0;
        run_op(32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678, "after_reset");

        // Random traffic against the a*b model.
        for (int n = 0; n < 8000; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       begin a = '0;           b = $urandom;     end
                1:       begin a = $urandom;     b = '0;           end
                2:       begin a = '1;           b = $urandom;     end
                default: begin a = $urandom;     b = $urandom;     end
            endcase
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule : tb_mult32_tile_sequencer
`default_nettype wire
